// File: rtl/gift_crypto_ctrl.sv
// ============================================================================
// gift_crypto_ctrl : request sequencer in front of one GIFT encrypt core and
//                    one GIFT decrypt core, with timeout watchdog and cycle count
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module gift_crypto_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             inClk,
   input  logic             inRst,
   input  logic             inReqValid,
   output logic             outReqReady,
   input  logic             inReqDec,
   input  logic             inReqKeyNew,
   input  logic [127:0]     inReqKey,
   input  logic [127:0]     inReqData,
   output logic             outRspValid,
   input  logic             inRspReady,
   output logic [127:0]     outRspData,
   output logic             outRspDec,
   output logic             outRspErr,
   output logic [CNT_W-1:0] outRspCycles,
   output logic             outEncKeyWr,
   output logic             outEncDataWr,
   output logic             outDecKeyWr,
   output logic             outDecDataWr,
   output logic [127:0]     outCoreKey,
   output logic [127:0]     outCoreData,
   input  logic [127:0]     inEncData,
   input  logic [127:0]     inDecData,
   input  logic             inEncBusy,
   input  logic             inDecBusy
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_ARM  = 3'd2,
      ST_RUN  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t           state;
   logic             req_dec;
   logic             enc_key_ok;
   logic             dec_key_ok;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             sel_busy;
   logic [127:0]     sel_data;
   logic             key_wr_needed;
   logic             accept;

   assign cnt_next      = (&cnt) ? cnt : cnt + CNT_W'(1);
   assign sel_busy      = req_dec ? inDecBusy : inEncBusy;
   assign sel_data      = req_dec ? inDecData : inEncData;
   assign outReqReady   = (state == ST_IDLE) && !inEncBusy && !inDecBusy;
   assign accept        = inReqValid && outReqReady;
   // a core that has never been given a key since reset must get one now
   assign key_wr_needed = inReqKeyNew || (inReqDec ? !dec_key_ok : !enc_key_ok);

   always_ff @(posedge inClk) begin
      if (inRst) begin
         state        <= ST_IDLE;
         req_dec      <= 1'b0;
         enc_key_ok   <= 1'b0;
         dec_key_ok   <= 1'b0;
         cnt          <= '0;
         outRspValid  <= 1'b0;
         outRspData   <= '0;
         outRspDec    <= 1'b0;
         outRspErr    <= 1'b0;
         outRspCycles <= '0;
         outEncKeyWr  <= 1'b0;
         outEncDataWr <= 1'b0;
         outDecKeyWr  <= 1'b0;
         outDecDataWr <= 1'b0;
         outCoreKey   <= '0;
         outCoreData  <= '0;
      end else begin
         // strobes and the shared core bus are only live for the LOAD cycle
         outEncKeyWr  <= 1'b0;
         outEncDataWr <= 1'b0;
         outDecKeyWr  <= 1'b0;
         outDecDataWr <= 1'b0;
         outCoreKey   <= '0;
         outCoreData  <= '0;

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  req_dec     <= inReqDec;
                  outCoreData <= inReqData;
                  if (inReqDec) begin
                     outDecDataWr <= 1'b1;
                  end else begin
                     outEncDataWr <= 1'b1;
                  end
                  if (key_wr_needed) begin
                     outCoreKey <= inReqKey;
                     if (inReqDec) begin
                        outDecKeyWr <= 1'b1;
                        dec_key_ok  <= 1'b1;
                     end else begin
                        outEncKeyWr <= 1'b1;
                        enc_key_ok  <= 1'b1;
                     end
                  end
                  state <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               state <= ST_ARM;
            end

            ST_ARM: begin
               cnt   <= '0;
               state <= ST_RUN;
            end

            ST_RUN: begin
               cnt <= cnt_next;
               if (!sel_busy) begin
                  outRspData   <= sel_data;
                  outRspErr    <= 1'b0;
                  outRspDec    <= req_dec;
                  outRspCycles <= cnt_next;
                  outRspValid  <= 1'b1;
                  state        <= ST_DONE;
               end else if (cnt_next >= TIMEOUT_C) begin
                  outRspData   <= '0;
                  outRspErr    <= 1'b1;
                  outRspDec    <= req_dec;
                  outRspCycles <= cnt_next;
                  outRspValid  <= 1'b1;
                  state        <= ST_DONE;
               end
            end

            ST_DONE: begin
               if (inRspReady) begin
                  outRspValid <= 1'b0;
                  state       <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
